fetch_pc_gen: RTL and testbench

Parametrised successor to the fetch-stage PC register. It holds the program counter and drives it to instruction memory over a valid/ready handshake. It applies sequential, exception (`req`) and `eret` redirects with fixed priority, and never loses a redirect that arrives while a fetch is waiting. It also flags misaligned or out-of-range fetch addresses. Sits between the NPC logic and the instruction memory, ahead of the F/D pipeline register.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/fetch_addr_check.sv | 25 ++
 rtl/fetch_pc_gen.sv | 103 ++++++++++
 tb/tb_fetch_pc_gen.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants: exception codes, default fetch-side address map and
// the fetch PC generator state type.
package cpu_pkg;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] DEF_HANDLER_PC = 32'h0000_4180;
  localparam logic [31:0] DEF_TEXT_BASE  = 32'h0000_3000;
  localparam logic [31:0] DEF_TEXT_LAST  = 32'h0000_6FFC;

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_addr_check.sv
// Combinational word-alignment and address-window check raising AdEL.
// Kept separate so the data-side load/store check can reuse it.
module fetch_addr_check
  import cpu_pkg::*;
#(
  parameter int               XLEN      = 32,
  parameter logic [XLEN-1:0]  TEXT_BASE = XLEN'(DEF_TEXT_BASE),
  parameter logic [XLEN-1:0]  TEXT_LAST = XLEN'(DEF_TEXT_LAST)
) (
  input  logic [XLEN-1:0] addr,
  output logic            fault,
  output logic [4:0]      excode
);

  logic misaligned;
  logic out_of_range;

  always_comb begin
    misaligned   = (addr[1:0] != 2'b00);
    out_of_range = (addr < TEXT_BASE) || (addr > TEXT_LAST);
    fault        = misaligned || out_of_range;
    excode       = fault ? EXC_ADEL : EXC_NONE;
  end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch-stage program counter with valid/ready request to instruction memory.
// Redirects that arrive while a request is waiting are parked until it fires.
module fetch_pc_gen
  import cpu_pkg::*;
#(
  parameter int               XLEN       = 32,
  parameter logic [XLEN-1:0]  RESET_PC   = XLEN'(DEF_RESET_PC),
  parameter logic [XLEN-1:0]  HANDLER_PC = XLEN'(DEF_HANDLER_PC),
  parameter logic [XLEN-1:0]  TEXT_BASE  = XLEN'(DEF_TEXT_BASE),
  parameter logic [XLEN-1:0]  TEXT_LAST  = XLEN'(DEF_TEXT_LAST)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic [XLEN-1:0] npc,
  input  logic            req,
  input  logic            eret,
  input  logic [XLEN-1:0] epc,
  output logic [XLEN-1:0] pc,
  output logic            fetch_valid,
  input  logic            fetch_ready,
  output logic            pc_fault,
  output logic [4:0]      excode
);

  fetch_state_e    state, state_d;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] redir_pc, redir_pc_d;
  logic            redir_is_req, redir_is_req_d;
  logic            fire;
  logic [XLEN-1:0] new_tgt;
  logic [XLEN-1:0] merged_tgt;
  logic            merged_is_req;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= RUN;
      pc           <= RESET_PC;
      fetch_valid  <= 1'b0;
      redir_pc     <= '0;
      redir_is_req <= 1'b0;
    end else begin
      state        <= state_d;
      pc           <= pc_d;
      fetch_valid  <= 1'b1;
      redir_pc     <= redir_pc_d;
      redir_is_req <= redir_is_req_d;
    end
  end

  always_comb begin
    state_d        = state;
    pc_d           = pc;
    redir_pc_d     = redir_pc;
    redir_is_req_d = redir_is_req;
    fire           = fetch_valid && fetch_ready;
    new_tgt        = req ? HANDLER_PC : epc;

    // A parked exception outranks any later eret; a fresh req always wins.
    merged_tgt    = redir_pc;
    merged_is_req = redir_is_req;
    if (req) begin
      merged_tgt    = HANDLER_PC;
      merged_is_req = 1'b1;
    end else if (eret && !redir_is_req) begin
      merged_tgt    = epc;
      merged_is_req = 1'b0;
    end

    case (state)
      RUN: begin
        if (fire) begin
          if (req || eret) pc_d = new_tgt;
          else if (!stall) pc_d = npc;
        end else if (req || eret) begin
          redir_pc_d     = new_tgt;
          redir_is_req_d = req;
          state_d        = PEND;
        end
      end
      PEND: begin
        redir_pc_d     = merged_tgt;
        redir_is_req_d = merged_is_req;
        if (fire) begin
          pc_d    = merged_tgt;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  fetch_addr_check #(
    .XLEN      (XLEN),
    .TEXT_BASE (TEXT_BASE),
    .TEXT_LAST (TEXT_LAST)
  ) u_addr_check (
    .addr   (pc),
    .fault  (pc_fault),
    .excode (excode)
  );

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Bench for fetch_pc_gen: directed scenarios then random traffic, all checked
// against a cycle-level behavioural model of the fetch redirect rules.
module tb_fetch_pc_gen;

  localparam logic [31:0] RST_PC  = 32'h0000_3000;
  localparam logic [31:0] HND_PC  = 32'h0000_4180;
  localparam logic [31:0] T_BASE  = 32'h0000_3000;
  localparam logic [31:0] T_LAST  = 32'h0000_6FFC;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, req, eret, fetch_ready;
  logic [31:0] npc, epc;
  logic [31:0] pc;
  logic        fetch_valid, pc_fault;
  logic [4:0]  excode;

  int checks = 0;
  int errors = 0;

  // Reference state: architectural PC, request valid, and at most one
  // remembered redirect (target + whether it came from an exception).
  logic [31:0] m_pc;
  bit          m_valid;
  bit          m_pend;
  logic [31:0] m_tgt;
  bit          m_isreq;

  always #5 clk = ~clk;

  fetch_pc_gen dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .npc         (npc),
    .req         (req),
    .eret        (eret),
    .epc         (epc),
    .pc          (pc),
    .fetch_valid (fetch_valid),
    .fetch_ready (fetch_ready),
    .pc_fault    (pc_fault),
    .excode      (excode)
  );

  function automatic bit bad_addr(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a < T_BASE) || (a > T_LAST);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".pc"}, pc, m_pc);
    chk({tag, ".valid"}, {31'd0, fetch_valid}, {31'd0, m_valid});
    chk({tag, ".fault"}, {31'd0, pc_fault}, {31'd0, bad_addr(m_pc)});
    chk({tag, ".excode"}, {27'd0, excode}, bad_addr(m_pc) ? 32'd4 : 32'd0);
  endtask

  // One clock: drive inputs, advance the model by the redirect rules, check.
  task automatic step(input string tag, input bit r, input bit e, input logic [31:0] ep,
                      input bit st, input logic [31:0] np, input bit rdy);
    bit fire;
    req = r; eret = e; epc = ep; stall = st; npc = np; fetch_ready = rdy;
    fire = m_valid && rdy;
    if (!m_pend) begin
      if (fire) begin
        if (r) m_pc = HND_PC;
        else if (e) m_pc = ep;
        else if (!st) m_pc = np;
      end else if (r || e) begin
        m_pend  = 1;
        m_tgt   = r ? HND_PC : ep;
        m_isreq = r;
      end
    end else begin
      if (r) begin
        m_tgt = HND_PC; m_isreq = 1;
      end else if (e && !m_isreq) begin
        m_tgt = ep;
      end
      if (fire) begin
        m_pc = m_tgt; m_pend = 0;
      end
    end
    m_valid = 1;
    @(posedge clk);
    #1;
    chk_model(tag);
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_valid = 0; m_pend = 0; m_tgt = '0; m_isreq = 0;
  endtask

  initial begin
    logic [31:0] pc_before;
    reset = 1'b0; stall = 0; req = 0; eret = 0; fetch_ready = 0; npc = '0; epc = '0;
    model_reset();
    #12;
    chk_model("reset");
    #5 reset = 1'b1;
    @(posedge clk); #1;
    m_valid = 1;
    chk_model("first_cycle");
    chk("first_pc", pc, 32'h3000);

    // Sequential fetch.
    step("seq1", 0, 0, 0, 0, m_pc + 4, 1);
    step("seq2", 0, 0, 0, 0, m_pc + 4, 1);
    chk("seq_pc", pc, 32'h3008);

    // Stall holds, req overrides stall.
    for (int i = 0; i < 3; i++) step("stall", 0, 0, 0, 1, m_pc + 4, 1);
    chk("stall_hold", pc, 32'h3008);
    step("req_stall", 1, 0, 0, 1, m_pc + 4, 1);
    chk("req_stall_pc", pc, HND_PC);

    // Parked eret then req, single fire -> handler.
    pc_before = pc;
    step("w_eret", 0, 1, 32'h3010, 0, 32'h5000, 0);
    step("w_idle", 0, 0, 0, 0, 32'h5000, 0);
    step("w_req", 1, 0, 0, 0, 32'h5000, 0);
    chk("w_stable", pc, pc_before);
    step("w_fire", 0, 0, 0, 0, 32'h5000, 1);
    chk("w_fire_pc", pc, HND_PC);
    step("w_after", 0, 0, 0, 0, 32'h3100, 1);
    chk("w_after_pc", pc, 32'h3100);

    // Parked req is not displaced by a later eret.
    step("p_req", 1, 0, 0, 0, 32'h3200, 0);
    step("p_eret", 0, 1, 32'h3020, 0, 32'h3200, 0);
    step("p_fire", 0, 0, 0, 0, 32'h3200, 1);
    chk("p_fire_pc", pc, HND_PC);

    // Address fault boundaries.
    step("f_mis", 0, 0, 0, 0, 32'h3002, 1);
    chk("f_mis_fault", {31'd0, pc_fault}, 32'd1);
    chk("f_mis_exc", {27'd0, excode}, 32'd4);
    step("f_hi", 0, 0, 0, 0, 32'h7000, 1);
    chk("f_hi_fault", {31'd0, pc_fault}, 32'd1);
    step("f_last", 0, 0, 0, 0, 32'h6FFC, 1);
    chk("f_last_fault", {31'd0, pc_fault}, 32'd0);
    step("f_lo", 0, 0, 0, 0, 32'h2FFC, 1);
    chk("f_lo_fault", {31'd0, pc_fault}, 32'd1);
    step("f_base", 0, 0, 0, 0, 32'h3000, 1);
    chk("f_base_fault", {31'd0, pc_fault}, 32'd0);

    // Asynchronous reset while a redirect is parked.
    step("r_eret", 0, 1, 32'h3040, 0, 32'h3004, 0);
    #3 reset = 1'b0;
    #1;
    model_reset();
    chk_model("r_async");
    #2 reset = 1'b1;
    req = 0; eret = 0;
    step("r_rise", 0, 0, 0, 0, 32'h3004, 1);
    step("r_noredir", 0, 0, 0, 0, 32'h3004, 1);
    chk("r_noredir_pc", pc, 32'h3004);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      bit          r, e, st, rdy;
      logic [31:0] np, ep;
      r   = ($urandom_range(0, 7) == 0);
      e   = ($urandom_range(0, 5) == 0);
      st  = ($urandom_range(0, 3) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 3))
        0, 1: np = m_pc + 4;
        2:    np = T_BASE + ($urandom_range(0, 16'h0FFF) << 2);
        default: np = $urandom;
      endcase
      ep = ($urandom_range(0, 1) == 0) ? (T_BASE + ($urandom_range(0, 255) << 2)) : $urandom;
      step("rand", r, e, ep, st, np, rdy);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
